// File: rtl/multiply_accumulate.sv
// Streaming pipelined multiply-accumulate: sums operand products per packet and emits one result on the last beat.
// Optional build macro MULTIPLY_ACCUMULATE_SATURATE_EN clamps every accumulation to the ACCW range instead of wrapping.
module multiply_accumulate #(
    parameter int ARGW   = 16,
    parameter int ACCW   = 40,
    parameter int STAGES = 2,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arg_valid,
    output logic              arg_ready,
    input  logic [2*ARGW-1:0] arg_data,
    input  logic              arg_last,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACCW-1:0]   res_data
);

    logic              en;
    logic [2*ARGW-1:0] op_a;
    logic [2*ARGW-1:0] op_b;
    logic [2*ARGW-1:0] prod_raw;
    logic [ACCW-1:0]   prod_ext;
    logic [ACCW-1:0]   sum;

    logic [ACCW-1:0]   prod_q [STAGES];
    logic [ACCW-1:0]   prod_d [STAGES];
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] last_q;
    logic [STAGES-1:0] last_d;
    logic [ACCW-1:0]   acc_q;
    logic [ACCW-1:0]   acc_d;
    logic [ACCW-1:0]   res_data_q;
    logic [ACCW-1:0]   res_data_d;
    logic              res_valid_q;
    logic              res_valid_d;

    // The whole pipe advances together; a stalled result freezes every stage.
    assign en        = !res_valid_q || res_ready;
    assign arg_ready = en && !reset;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

    always_comb begin
        if (SIGNED != 0) begin
            op_a = {{ARGW{arg_data[ARGW-1]}}, arg_data[ARGW-1:0]};
            op_b = {{ARGW{arg_data[2*ARGW-1]}}, arg_data[2*ARGW-1:ARGW]};
        end else begin
            op_a = {{ARGW{1'b0}}, arg_data[ARGW-1:0]};
            op_b = {{ARGW{1'b0}}, arg_data[2*ARGW-1:ARGW]};
        end
        prod_raw = op_a * op_b;
        if (SIGNED != 0) begin
            prod_ext = ACCW'($signed(prod_raw));
        end else begin
            prod_ext = ACCW'(prod_raw);
        end
    end

`ifdef MULTIPLY_ACCUMULATE_SATURATE_EN
    logic [ACCW:0] sum_wide;

    always_comb begin
        if (SIGNED != 0) begin
            sum_wide = {acc_q[ACCW-1], acc_q} + {prod_q[STAGES-1][ACCW-1], prod_q[STAGES-1]};
            // Top two bits disagree only on signed overflow; bit ACCW holds the true sign.
            if (sum_wide[ACCW] != sum_wide[ACCW-1]) begin
                sum = sum_wide[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
            end else begin
                sum = sum_wide[ACCW-1:0];
            end
        end else begin
            sum_wide = {1'b0, acc_q} + {1'b0, prod_q[STAGES-1]};
            sum      = sum_wide[ACCW] ? {ACCW{1'b1}} : sum_wide[ACCW-1:0];
        end
    end
`else
    always_comb begin
        sum = acc_q + prod_q[STAGES-1];
    end
`endif

    always_comb begin
        vld_d       = vld_q;
        last_d      = last_q;
        prod_d      = prod_q;
        acc_d       = acc_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        if (en) begin
            vld_d[0]  = arg_valid;
            last_d[0] = arg_last;
            prod_d[0] = prod_ext;
            for (int k = 1; k < STAGES; k++) begin
                vld_d[k]  = vld_q[k-1];
                last_d[k] = last_q[k-1];
                prod_d[k] = prod_q[k-1];
            end
            // With en high any held result is being taken this cycle.
            res_valid_d = 1'b0;
            if (vld_q[STAGES-1]) begin
                if (last_q[STAGES-1]) begin
                    res_data_d  = sum;
                    res_valid_d = 1'b1;
                    acc_d       = '0;
                end else begin
                    acc_d = sum;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q       <= '0;
            last_q      <= '0;
            acc_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                prod_q[k] <= '0;
            end
        end else begin
            vld_q       <= vld_d;
            last_q      <= last_d;
            acc_q       <= acc_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            for (int k = 0; k < STAGES; k++) begin
                prod_q[k] <= prod_d[k];
            end
        end
    end

endmodule

// File: tb/tb_multiply_accumulate.sv
// Bench for multiply_accumulate: directed scenarios on a signed 2-stage instance, randomized packets on an unsigned 1-stage one.
// Expected sums come from an integer packet model; MULTIPLY_ACCUMULATE_SATURATE_EN selects clamping in that model too.
module tb_multiply_accumulate;

    localparam int ARGW = 16;
    localparam int ACCW = 40;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              arg_valid1, arg_ready1, arg_last1, res_valid1, res_ready1;
    logic [2*ARGW-1:0] arg_data1;
    logic [ACCW-1:0]   res_data1;
    logic              arg_valid2, arg_ready2, arg_last2, res_valid2, res_ready2;
    logic [2*ARGW-1:0] arg_data2;
    logic [ACCW-1:0]   res_data2;

    int checks = 0;
    int errors = 0;
    bit done2  = 1'b0;

    logic [ACCW-1:0] exp1_q[$];
    logic [ACCW-1:0] exp2_q[$];
    logic [ACCW-1:0] got1_q[$];
    logic [ACCW-1:0] got2_q[$];
    logic [ACCW-1:0] m_acc1 = '0;
    logic [ACCW-1:0] m_acc2 = '0;

    multiply_accumulate #(.ARGW(ARGW), .ACCW(ACCW), .STAGES(2), .SIGNED(1)) u_dut (
        .clk(clk), .reset(reset),
        .arg_valid(arg_valid1), .arg_ready(arg_ready1), .arg_data(arg_data1), .arg_last(arg_last1),
        .res_valid(res_valid1), .res_ready(res_ready1), .res_data(res_data1)
    );

    multiply_accumulate #(.ARGW(ARGW), .ACCW(ACCW), .STAGES(1), .SIGNED(0)) u_dut_u (
        .clk(clk), .reset(reset),
        .arg_valid(arg_valid2), .arg_ready(arg_ready2), .arg_data(arg_data2), .arg_last(arg_last2),
        .res_valid(res_valid2), .res_ready(res_ready2), .res_data(res_data2)
    );

    // One accumulation step in plain integer arithmetic.
    function automatic logic [ACCW-1:0] model_step(input logic [ACCW-1:0] acc, input logic [15:0] a,
                                                   input logic [15:0] b, input bit sgn);
        longint p;
        longint s;
        longint lo;
        longint hi;
        if (sgn) begin
            p = longint'($signed(a)) * longint'($signed(b));
            s = longint'($signed(acc)) + p;
            lo = -(longint'(1) <<< 39);
            hi = (longint'(1) <<< 39) - 1;
        end else begin
            p = longint'(a) * longint'(b);
            s = longint'(acc) + p;
            lo = 0;
            hi = (longint'(1) <<< 40) - 1;
        end
`ifdef MULTIPLY_ACCUMULATE_SATURATE_EN
        if (s < lo) s = lo;
        if (s > hi) s = hi;
`endif
        return ACCW'(s);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && res_valid1 && res_ready1) got1_q.push_back(res_data1);
        if (!reset && res_valid2 && res_ready2) got2_q.push_back(res_data2);
    end

    task automatic beat(input bit sel, input logic [15:0] a, input logic [15:0] b, input logic last);
        int n;
        n = 0;
        if (sel) begin
            arg_valid2 = 1'b1; arg_data2 = {b, a}; arg_last2 = last;
        end else begin
            arg_valid1 = 1'b1; arg_data1 = {b, a}; arg_last1 = last;
        end
        @(negedge clk);
        while (!(sel ? arg_ready2 : arg_ready1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("beat_accept", 64'(sel ? arg_ready2 : arg_ready1), 64'd1);
        if (sel ? arg_ready2 : arg_ready1) begin
            @(posedge clk);
            if (sel) begin
                m_acc2 = model_step(m_acc2, a, b, 1'b0);
                if (last) begin exp2_q.push_back(m_acc2); m_acc2 = '0; end
            end else begin
                m_acc1 = model_step(m_acc1, a, b, 1'b1);
                if (last) begin exp1_q.push_back(m_acc1); m_acc1 = '0; end
            end
            #1;
        end
        if (sel) begin
            arg_valid2 = 1'b0; arg_last2 = 1'b0;
        end else begin
            arg_valid1 = 1'b0; arg_last1 = 1'b0;
        end
    endtask

    // Waits for every expected result, then checks count and order.
    task automatic compare_all(input bit sel, input string tag);
        int n;
        int k;
        n = sel ? exp2_q.size() : exp1_q.size();
        k = 0;
        while ((sel ? got2_q.size() : got1_q.size()) < n && k < 20000) begin
            @(negedge clk);
            k++;
        end
        repeat (5) @(negedge clk);
        check({tag, "_count"}, 64'(sel ? got2_q.size() : got1_q.size()), 64'(n));
        if (sel) begin
            while (exp2_q.size() > 0 && got2_q.size() > 0) check(tag, 64'(got2_q.pop_front()), 64'(exp2_q.pop_front()));
        end else begin
            while (exp1_q.size() > 0 && got1_q.size() > 0) check(tag, 64'(got1_q.pop_front()), 64'(exp1_q.pop_front()));
        end
        got1_q.delete();
        got2_q.delete();
        exp1_q.delete();
        exp2_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (1000000) @(posedge clk);
        $display("FAIL watchdog: no finish within 1000000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        arg_valid1 = 1'b0; arg_data1 = '0; arg_last1 = 1'b0; res_ready1 = 1'b1;
        arg_valid2 = 1'b0; arg_data2 = '0; arg_last2 = 1'b0; res_ready2 = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_arg_ready", 64'(arg_ready1), 64'd0);
        check("reset_res_valid", 64'(res_valid1), 64'd0);
        check("reset_res_data", 64'(res_data1), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("idle_arg_ready", 64'(arg_ready1), 64'd1);
        @(posedge clk);
        #1;

        // Single-beat packets with latency probe.
        beat(1'b0, 16'h7FFF, 16'h7FFF, 1'b1);
        @(negedge clk);
        check("lat_edge_t", 64'(res_valid1), 64'd0);
        @(negedge clk);
        check("lat_edge_t1", 64'(res_valid1), 64'd0);
        @(negedge clk);
        check("lat_edge_t2", 64'(res_valid1), 64'd1);
        check("lat_data", 64'(res_data1), 64'(exp1_q[0]));
        @(posedge clk);
        #1;
        compare_all(1'b0, "single_max");
        beat(1'b0, 16'hFFFF, 16'h0001, 1'b1);
        compare_all(1'b0, "single_neg");

        // Four-beat packet; nothing may appear before the last beat.
        beat(1'b0, 16'd3, 16'd4, 1'b0);
        beat(1'b0, 16'hFFFE, 16'd5, 1'b0);
        beat(1'b0, 16'd100, 16'd100, 1'b0);
        repeat (4) begin
            @(negedge clk);
            check("pkt4_no_early", 64'(res_valid1), 64'd0);
        end
        @(posedge clk);
        #1;
        beat(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
        compare_all(1'b0, "pkt4");

        // Backpressure: result held, intake blocked.
        res_ready1 = 1'b0;
        beat(1'b0, 16'd2, 16'd3, 1'b1);
        beat(1'b0, 16'd4, 16'd5, 1'b0);
        beat(1'b0, 16'd6, 16'd7, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_arg_ready", 64'(arg_ready1), 64'd0);
            check("bp_res_valid", 64'(res_valid1), 64'd1);
            check("bp_res_data", 64'(res_data1), 64'(exp1_q[0]));
        end
        @(posedge clk);
        #1 res_ready1 = 1'b1;
        compare_all(1'b0, "bp_order");

        // Reset in the middle of a packet discards the partial sum.
        beat(1'b0, 16'd1000, 16'd1000, 1'b0);
        beat(1'b0, 16'd5, 16'd5, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        m_acc1 = '0;
        @(negedge clk);
        check("midrst_arg_ready", 64'(arg_ready1), 64'd0);
        check("midrst_res_valid", 64'(res_valid1), 64'd0);
        check("midrst_res_data", 64'(res_data1), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        beat(1'b0, 16'd2, 16'd3, 1'b1);
        compare_all(1'b0, "post_reset");

        // Long packet of the most negative operands: overflow path.
        for (int i = 1; i <= 600; i++) beat(1'b0, 16'h8000, 16'h8000, i == 600);
        compare_all(1'b0, "overflow600");

        // Unsigned single-stage instance: latency probe then random packets.
        beat(1'b1, 16'd3, 16'd5, 1'b1);
        @(negedge clk);
        check("u_lat_edge_t", 64'(res_valid2), 64'd0);
        @(negedge clk);
        check("u_lat_edge_t1", 64'(res_valid2), 64'd1);
        check("u_lat_data", 64'(res_data2), 64'(exp2_q[0]));
        @(posedge clk);
        #1;
        compare_all(1'b1, "u_single");

        fork
            begin
                for (int p = 0; p < 64; p++) begin
                    int len;
                    len = $urandom_range(1, 8);
                    for (int j = 0; j < len; j++) begin
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk);
                            #1;
                        end
                        beat(1'b1, 16'($urandom), 16'($urandom), j == len - 1);
                    end
                end
                compare_all(1'b1, "u_random");
                done2 = 1'b1;
            end
            begin
                while (!done2) begin
                    @(posedge clk);
                    #1 res_ready2 = ($urandom_range(0, 3) != 0);
                end
                res_ready2 = 1'b1;
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
